// File: rtl/dmem_byteen_ram.sv
// rtl/dmem_byteen_ram.sv - byte-enabled data memory with reset clear sweep and optional store trace
//
// Purpose: M-stage data memory. Partial-word stores are merged under a
// per-byte enable, and reads are combinational. After reset a CLEAR sweep
// zeroes one word per cycle. Writes issued during the sweep or outside the
// mapped window are dropped, and the first one is recorded in err/err_addr.
//
// Optional feature macro: DMEM_TRACE_EN. When it is defined, a registered
// store-trace port pulses once per committed write. When it is undefined,
// the trace ports are tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low
//   addr         in   byte address
//   wdata        in   store data, lanes aligned to byteen
//   byteen       in   per-byte write enable (all zero = no write)
//   pc           in   PC of the storing instruction (trace only)
//   rdata        out  word at addr (0 if busy or out of range)
//   busy         out  clear sweep in progress
//   err          out  sticky dropped-write flag
//   err_addr     out  aligned address of the first dropped write
//   trace_valid  out  one-cycle pulse per committed write
//   trace_pc     out  PC of the committed write
//   trace_addr   out  aligned address of the committed write
//   trace_data   out  merged word after the write
module dmem_byteen_ram #(
    parameter int          DATA_BYTES = 4,
    parameter int          DEPTH      = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               addr,
    input  logic [8*DATA_BYTES-1:0]   wdata,
    input  logic [DATA_BYTES-1:0]     byteen,
    input  logic [31:0]               pc,
    output logic [8*DATA_BYTES-1:0]   rdata,
    output logic                      busy,
    output logic                      err,
    output logic [31:0]               err_addr,
    output logic                      trace_valid,
    output logic [31:0]               trace_pc,
    output logic [31:0]               trace_addr,
    output logic [8*DATA_BYTES-1:0]   trace_data
);
    localparam int          W          = 8 * DATA_BYTES;
    localparam int          LB         = $clog2(DATA_BYTES);
    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ALIGN_MASK = ~(32'(DATA_BYTES) - 32'd1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            err_q;
    logic [31:0]     err_addr_q;
    logic [W-1:0]    mem_q [DEPTH];

    logic [31:0]     offset;
    logic [31:0]     idx_full;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            any_be;
    logic            do_write;
    logic            drop;
    logic            clear_wr;
    logic [W-1:0]    old_word;
    logic [W-1:0]    merged_d;
    logic [31:0]     aligned_addr;

    // Unsigned wrap makes addresses below BASE_ADDR huge, but the explicit
    // compare against BASE_ADDR keeps the test independent of DEPTH.
    assign offset       = addr - BASE_ADDR;
    assign idx_full     = offset >> LB;
    assign in_range     = (addr >= BASE_ADDR) && (idx_full < 32'(DEPTH));
    assign idx          = idx_full[AW-1:0];
    assign aligned_addr = addr & ALIGN_MASK;

    assign busy     = (state_q == ST_CLEAR);
    assign any_be   = |byteen;
    assign clear_wr = reset && (state_q == ST_CLEAR);
    assign do_write = reset && !busy && any_be && in_range;
    assign drop     = reset && any_be && (busy || !in_range);

    assign old_word = mem_q[idx];

    always_comb begin
        merged_d = old_word;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (byteen[b]) begin
                merged_d[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    assign rdata = (in_range && !busy) ? old_word : '0;

    // Storage has no reset of its own; the sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem_q[cnt_q] <= '0;
        end else if (do_write) begin
            mem_q[idx] <= merged_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (state_q == ST_CLEAR) begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_q <= ST_RUN;
                end
                cnt_q <= cnt_q + AW'(1);
            end
            // Only the first drop is recorded; later ones leave err_addr alone.
            if (drop && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= aligned_addr;
            end
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

`ifdef DMEM_TRACE_EN
    logic         tr_valid_q;
    logic [31:0]  tr_pc_q;
    logic [31:0]  tr_addr_q;
    logic [W-1:0] tr_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tr_valid_q <= 1'b0;
            tr_pc_q    <= '0;
            tr_addr_q  <= '0;
            tr_data_q  <= '0;
        end else begin
            tr_valid_q <= do_write;
            if (do_write) begin
                tr_pc_q   <= pc;
                tr_addr_q <= aligned_addr;
                tr_data_q <= merged_d;
            end
        end
    end

    assign trace_valid = tr_valid_q;
    assign trace_pc    = tr_pc_q;
    assign trace_addr  = tr_addr_q;
    assign trace_data  = tr_data_q;
`else
    logic unused_trace;
    assign unused_trace = ^pc;

    assign trace_valid = 1'b0;
    assign trace_pc    = '0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
`endif

endmodule

// File: tb/tb_dmem_byteen_ram.sv
// tb/tb_dmem_byteen_ram.sv - self-checking bench for dmem_byteen_ram
module tb_dmem_byteen_ram;
    localparam int          DB   = 4;
    localparam int          DEP  = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef DMEM_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        busy;
    logic        err;
    logic [31:0] err_addr;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    dmem_byteen_ram #(
        .DATA_BYTES (DB),
        .DEPTH      (DEP),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .addr        (addr),
        .wdata       (wdata),
        .byteen      (byteen),
        .pc          (pc),
        .rdata       (rdata),
        .busy        (busy),
        .err         (err),
        .err_addr    (err_addr),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } tr_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] rd_q [$];
    tr_t         tr_q [$];
    logic [31:0] mdl [DEP];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Combinational read; expected word comes from the scoreboard queue.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr   = a;
        byteen = 4'b0000;
        rd_q.push_back(exp);
        #1;
        check(tag, rdata, rd_q.pop_front());
    endtask

    // One store cycle. Before the edge rdata must still show the old word
    // (0 when the store is going to be dropped); after the edge the trace
    // port is checked against the pushed expectation.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] p, input bit commit, input string tag);
        int          i;
        logic [31:0] nw;
        tr_t         t;
        logic [31:0] pre;
        i   = int'((a - BASE) >> 2);
        pre = 32'h0;
        addr = a; wdata = d; byteen = be; pc = p;
        if (commit) begin
            pre = mdl[i];
            nw  = mdl[i];
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
            tr_q.push_back('{pc: p, addr: a & 32'hFFFF_FFFC, data: nw});
            mdl[i] = nw;
        end
        #1;
        check({tag, "_pre_rdata"}, rdata, pre);
        tick;
        if (commit) begin
            t = tr_q.pop_front();
            check({tag, "_trace_valid"}, {31'h0, trace_valid}, {31'h0, TRACE});
            check({tag, "_trace_pc"},   trace_pc,   TRACE ? t.pc   : 32'h0);
            check({tag, "_trace_addr"}, trace_addr, TRACE ? t.addr : 32'h0);
            check({tag, "_trace_data"}, trace_data, TRACE ? t.data : 32'h0);
        end else begin
            check({tag, "_no_trace"}, {31'h0, trace_valid}, 32'h0);
        end
        byteen = 4'b0000;
    endtask

    task automatic wait_sweep(input int start, input string tag);
        int n;
        n = start;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
        end
        check(tag, n, DEP);
        for (int k = 0; k < DEP; k++) mdl[k] = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; addr = BASE; wdata = 32'h0; byteen = 4'b0000; pc = 32'h0;
        tick;
        tick;

        // Reset values
        check("rst_busy",        {31'h0, busy},        32'h1);
        check("rst_err",         {31'h0, err},         32'h0);
        check("rst_err_addr",    err_addr,             32'h0);
        check("rst_trace_valid", {31'h0, trace_valid}, 32'h0);
        check("rst_trace_pc",    trace_pc,             32'h0);
        check("rst_trace_addr",  trace_addr,           32'h0);
        check("rst_trace_data",  trace_data,           32'h0);

        // Sweep with a store in sweep cycle 3
        rst_n = 1'b1;
        tick;
        tick;
        wr(BASE + 32'h8, 32'hCAFE_F00D, 4'b1111, 32'h0040_0000, 1'b0, "busy_drop");
        check("busy_drop_err",      {31'h0, err}, 32'h1);
        check("busy_drop_err_addr", err_addr,     BASE + 32'h8);
        wait_sweep(3, "sweep1_len");
        for (int k = 0; k < DEP; k++) rd(BASE + 32'(4*k), 32'h0, "sweep1_zero");

        // Back-to-back fill with nonzero words
        for (int k = 0; k < DEP; k++)
            wr(BASE + 32'(4*k), 32'h1000_0000 + 32'h0101_0101 * 32'(k + 1), 4'b1111,
               32'h0040_0100 + 32'(4*k), 1'b1, "fill");
        for (int k = 0; k < DEP; k++) rd(BASE + 32'(4*k), mdl[k], "fill_read");

        // Reset again, then reset mid-sweep at cycle 10
        rst_n = 1'b0;
        tick;
        tick;
        check("rst2_err",      {31'h0, err}, 32'h0);
        check("rst2_err_addr", err_addr,     32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) tick;
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        wait_sweep(0, "sweep2_len");
        for (int k = 0; k < DEP; k++) rd(BASE + 32'(4*k), 32'h0, "sweep2_zero");
        check("sweep2_err", {31'h0, err}, 32'h0);

        // Byte merge
        wr(BASE + 32'h10, 32'h1122_3344, 4'b1111, 32'h0040_0200, 1'b1, "merge_a");
        wr(BASE + 32'h12, 32'hAABB_CCDD, 4'b0101, 32'h0040_0204, 1'b1, "merge_b");
        rd(BASE + 32'h10, 32'h11BB_33DD, "merge_read");
        rd(BASE + 32'h13, 32'h11BB_33DD, "low_bits_ignored");

        // Out of range
        wr(32'h0000_0FFC, 32'h5555_5555, 4'b1111, 32'h0040_0300, 1'b0, "below_base");
        check("oor_err",      {31'h0, err}, 32'h1);
        check("oor_err_addr", err_addr,     32'h0000_0FFC);
        wr(BASE + 32'h40, 32'h6666_6666, 4'b0011, 32'h0040_0304, 1'b0, "above_top");
        check("oor2_err",      {31'h0, err}, 32'h1);
        check("oor2_err_addr", err_addr,     32'h0000_0FFC);
        rd(BASE + 32'h40, 32'h0, "oor_read_hi");
        rd(32'h0000_0FFC, 32'h0, "oor_read_lo");
        rd(BASE + 32'h3C, 32'h0, "last_word");

        // Read-during-write on word 5 (pre-edge check inside wr)
        wr(BASE + 32'h14, 32'h1234_5678, 4'b1111, 32'h0040_0400, 1'b1, "rdw_a");
        wr(BASE + 32'h14, 32'hDEAD_BEEF, 4'b1111, 32'h0040_0404, 1'b1, "rdw_b");
        rd(BASE + 32'h14, 32'hDEAD_BEEF, "rdw_after");
        check("idle_trace", {31'h0, trace_valid}, 32'h0);
        rd(BASE + 32'h10, 32'h11BB_33DD, "merge_kept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
